// File: rtl/io_channel_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : io_channel_unit_if
// Description : Bundle of producer, CPU and consumer signals for io_channel_unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface io_channel_unit_if #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4,
  parameter int DEPTH    = 8
);
  localparam int CW   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int CNTW = $clog2(DEPTH) + 1;

  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS-1:0]       in_ready;
  logic [CW-1:0]             cpu_chan;
  logic                      cpu_rd;
  logic [WIDTH-1:0]          cpu_rdata;
  logic                      cpu_rd_empty;
  logic                      cpu_wr;
  logic [WIDTH-1:0]          cpu_wdata;
  logic                      cpu_wr_full;
  logic [CHANNELS*WIDTH-1:0] out_data;
  logic [CHANNELS-1:0]       out_valid;
  logic [CHANNELS-1:0]       out_ready;
  logic [CHANNELS-1:0]       drop_err;
  logic [CHANNELS*CNTW-1:0]  in_count;

  modport master (
    output in_data, in_valid, cpu_chan, cpu_rd, cpu_wr, cpu_wdata, out_ready,
    input  in_ready, cpu_rdata, cpu_rd_empty, cpu_wr_full, out_data, out_valid,
           drop_err, in_count
  );

  modport slave (
    input  in_data, in_valid, cpu_chan, cpu_rd, cpu_wr, cpu_wdata, out_ready,
    output in_ready, cpu_rdata, cpu_rd_empty, cpu_wr_full, out_data, out_valid,
           drop_err, in_count
  );
endinterface
`default_nettype wire

// File: rtl/io_channel_unit.sv
`default_nettype none
// ============================================================================
// Module      : io_channel_unit
// Description : Multi-channel CPU I/O: per-channel show-ahead input FIFOs and
//               one-entry output holding registers.
// Revision    : 1.0 - initial release
// ============================================================================
module io_channel_unit #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4,
  parameter int DEPTH    = 8
) (
  input  logic              clk,
  input  logic              clr,
  io_channel_unit_if.slave  bus
);
  localparam int CW   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = AW + 1;

  logic                w_chan_ok;
  logic [WIDTH-1:0]    w_head [CHANNELS];
  logic [CHANNELS-1:0] w_empty;
  logic [CHANNELS-1:0] w_out_full;

  // Only a non-power-of-two channel count can be addressed out of range.
  generate
    if ((1 << CW) == CHANNELS) begin : g_full_decode
      assign w_chan_ok = 1'b1;
    end else begin : g_partial_decode
      assign w_chan_ok = (int'(bus.cpu_chan) < CHANNELS);
    end
  endgenerate

  generate
    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
      localparam logic [CW-1:0] c_sel = CW'(k);

      logic [WIDTH-1:0] r_mem [DEPTH];
      logic [AW-1:0]    r_rd_ptr;
      logic [AW-1:0]    r_wr_ptr;
      logic [CNTW-1:0]  r_count;
      logic [WIDTH-1:0] r_out_data;
      logic             r_out_valid;
      logic             r_drop;
      logic             w_sel;
      logic             w_not_full;
      logic             w_push;
      logic             w_pop;
      logic             w_wr_acc;
      logic             w_wr_drop;

      assign w_sel      = w_chan_ok && (bus.cpu_chan == c_sel);
      assign w_not_full = (r_count != CNTW'(DEPTH));
      assign w_push     = bus.in_valid[k] && w_not_full;
      assign w_pop      = bus.cpu_rd && w_sel && (r_count != '0);
      assign w_wr_acc   = bus.cpu_wr && w_sel && !w_out_full[k];
      assign w_wr_drop  = bus.cpu_wr && w_sel && w_out_full[k];

      assign w_head[k]     = r_mem[r_rd_ptr];
      assign w_empty[k]    = (r_count == '0);
      assign w_out_full[k] = r_out_valid && !bus.out_ready[k];

      assign bus.in_ready[k]                  = w_not_full;
      assign bus.in_count[k*CNTW +: CNTW]     = r_count;
      assign bus.out_data[k*WIDTH +: WIDTH]   = r_out_data;
      assign bus.out_valid[k]                 = r_out_valid;
      assign bus.drop_err[k]                  = r_drop;

      // Storage is left unreset so it can map onto a register file.
      always_ff @(posedge clk) begin
        if (w_push && clr) begin
          r_mem[r_wr_ptr] <= bus.in_data[k*WIDTH +: WIDTH];
        end
      end

      always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
          r_rd_ptr <= '0;
          r_wr_ptr <= '0;
          r_count  <= '0;
        end else begin
          if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
          end
          if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
          end
          case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNTW'(1);
            2'b01:   r_count <= r_count - CNTW'(1);
            default: r_count <= r_count;
          endcase
        end
      end

      // A write landing on a draining register reloads it without a bubble.
      always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
          r_out_data  <= '0;
          r_out_valid <= 1'b0;
          r_drop      <= 1'b0;
        end else begin
          if (w_wr_acc) begin
            r_out_data  <= bus.cpu_wdata;
            r_out_valid <= 1'b1;
          end else if (r_out_valid && bus.out_ready[k]) begin
            r_out_valid <= 1'b0;
          end
          if (w_wr_drop) begin
            r_drop <= 1'b1;
          end
        end
      end
    end
  endgenerate

  always_comb begin
    bus.cpu_rdata    = '0;
    bus.cpu_rd_empty = 1'b1;
    bus.cpu_wr_full  = 1'b1;
    for (int i = 0; i < CHANNELS; i++) begin
      if (w_chan_ok && (bus.cpu_chan == CW'(i))) begin
        bus.cpu_rdata    = w_empty[i] ? '0 : w_head[i];
        bus.cpu_rd_empty = w_empty[i];
        bus.cpu_wr_full  = w_out_full[i];
      end
    end
  end
endmodule
`default_nettype wire

// File: doc/io_channel_unit.md
# io_channel_unit

Parametrised I/O block that replaces the CPU's single-word IN and OUT registers with several independent channels. Each channel has an input FIFO, filled by external producers through a valid/ready handshake and drained by the CPU's `in` instruction. Each channel also has a one-entry output holding register, loaded by the CPU's `out` instruction and drained by external consumers through a valid/ready handshake. The unit sits between the CPU datapath (rf_in mux and rf_a_out) and the board-level I/O.

## Interface
Parameters:
- WIDTH, 32, data word width in bits.
- CHANNELS, 4, number of channels (≥1; need not be a power of two).
- DEPTH, 8, entries per input FIFO (power of two, ≥2).
- CW, max(1,$clog2(CHANNELS)), channel-select width (derived).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- clr  in  1  reset, asynchronous, active-low.
- in_data  in  CHANNELS*WIDTH  producer data; channel k occupies bits [k*WIDTH +: WIDTH].
- in_valid  in  CHANNELS  producer valid, one bit per channel.
- in_ready  out  CHANNELS  FIFO k not full.
- cpu_chan  in  CW  channel addressed by the CPU this cycle.
- cpu_rd  in  1  pop the head of FIFO[cpu_chan].
- cpu_rdata  out  WIDTH  head of FIFO[cpu_chan] (show-ahead); 0 when empty.
- cpu_rd_empty  out  1  FIFO[cpu_chan] empty; the control unit stalls on it.
- cpu_wr  in  1  load cpu_wdata into OUT[cpu_chan].
- cpu_wdata  in  WIDTH  data to write.
- cpu_wr_full  out  1  OUT[cpu_chan] cannot accept a write this cycle.
- out_data  out  CHANNELS*WIDTH  holding-register contents, packed like in_data.
- out_valid  out  CHANNELS  holding register k occupied.
- out_ready  in  CHANNELS  consumer accepts channel k.
- drop_err  out  CHANNELS  sticky flag: a CPU write to channel k was discarded.
- in_count  out  CHANNELS*($clog2(DEPTH)+1)  occupancy of each FIFO, packed.

## Operation
- Input FIFO k:
  - Push when in_valid[k] && in_ready[k].
  - in_ready[k] = (count_k != DEPTH). It is a registered-state function only, with no combinational path from cpu_rd.
  - Pop when cpu_rd && cpu_chan==k && count_k != 0. A pop on an empty FIFO is ignored: no state change, no error.
  - Push and pop on the same edge: count unchanged, head advances, new tail stored.
  - Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH. Count is $clog2(DEPTH)+1 bits.
- cpu_rdata and cpu_rd_empty are combinational from cpu_chan and the FIFO state.
- Output holding register k:
  - cpu_wr_full = out_valid[cpu_chan] && !out_ready[cpu_chan].
  - A CPU write to k is accepted when !cpu_wr_full: out_data_k <= cpu_wdata, out_valid[k] <= 1.
  - Drain: out_valid[k] && out_ready[k] with no accepted write clears out_valid[k].
  - Drain and write on the same edge: the register reloads and out_valid stays 1. No bubble, no loss.
  - A write while full is discarded: out_data_k is unchanged and drop_err[k] <= 1. The flag clears only on reset.
- cpu_chan ≥ CHANNELS (non-power-of-two case):
  - cpu_rdata = 0, cpu_rd_empty = 1, cpu_wr_full = 1.
  - Reads and writes are ignored; drop_err is not set.
- Channels are fully independent. Producer, consumer and CPU activity on different channels in one cycle all take effect.

## Timing
- Reset (clr low, asynchronous), all forced within the same cycle:
  - All FIFO pointers and counts 0; in_ready all 1; in_count all 0.
  - out_valid 0, out_data 0, drop_err 0.
  - cpu_rdata 0, cpu_rd_empty 1, cpu_wr_full 0.
- Reset mid-transfer discards all FIFO and holding contents. Nothing is pushed or popped on the edge where clr deasserts if clr is still low at that edge.
- Producer-to-CPU latency: a word pushed at edge N is visible on cpu_rdata (with cpu_rd_empty=0) after edge N. It can be popped at edge N+1.
- CPU-to-consumer latency: a word written at edge N presents out_valid=1 after edge N.
- Full-to-space latency: in_ready rises one cycle after the pop that frees space.
- Throughput: one push, one pop, one write and one drain per channel per cycle.
- FIFO storage may be a register array. The memory read is not registered: show-ahead is required.

## Test plan
- Reset release, CHANNELS=4, DEPTH=8 -> in_ready=4'b1111, out_valid=0, drop_err=0, cpu_rd_empty=1, cpu_rdata=0.
- Push 0x11..0x18 into ch2, then a 9th word 0x19 -> in_ready[2]=0 after the 8th push; in_count[2]=8; 0x19 is not accepted. Eight pops return 0x11..0x18 in order, then cpu_rd_empty=1. Pointers wrap on a second fill with 0x21..0x28.
- Ch1 holding 3 entries; push 0xAA and pop in the same cycle -> in_count[1] stays 3; 0xAA returned last.
- cpu_wr 0xDEADBEEF to ch0 with out_ready[0]=0, then cpu_wr 0x1 -> out_data ch0=0xDEADBEEF, drop_err[0]=1. Next, write 0x2 with out_ready[0]=1 -> ch0 reloads to 0x2, out_valid[0] stays 1.
- CHANNELS=3, cpu_chan=3 with cpu_wr and cpu_rd -> no state change, cpu_rd_empty=1, cpu_wr_full=1, drop_err=0.
- clr pulsed low mid-stream with ch0 count=5 and out_valid[3]=1 -> immediately count=0, out_valid=0, in_ready all 1.
